// File: rtl/db_bounce_gen_pkg.sv
// db_pkg: shared types and constants for the bounce emulator and the
// debouncer checks that sit downstream of it.
package db_pkg;

  localparam int LFSR_W   = 16;
  localparam int DB_LIMIT = 4;

  // Button line order on btn[]
  localparam int CH_HS      = 0;
  localparam int CH_VS      = 1;
  localparam int CH_DF_UART = 2;
  localparam int CH_DF_VGA  = 3;

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_e;
  typedef enum logic {PH_A, PH_B} phase_e;

  // One Fibonacci step, taps 16,14,13,11, new bit shifted in at the bottom
  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

endpackage

// File: rtl/db_bounce_gen_if.sv
// db_bounce_gen_if: command handshake plus the emulated button lines.
// master = command initiator, slave = the bounce generator.
interface db_bounce_gen_if #(
  parameter int NUM_CH = 4
) ();

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_level;
  logic [NUM_CH-1:0] btn;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_ch, cmd_level,
    input  cmd_ready, btn, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_level,
    output cmd_ready, btn, busy, done, err
  );

endinterface

// File: rtl/db_bounce_gen_lfsr16.sv
// db_lfsr16: free-running 16-bit pseudo-random source with synchronous load.
// A load wins over a step on the same edge.
module db_lfsr16
  import db_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;

  // Hold the shift register: reset to SEED, reload on request, else step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= load_val_i;
    end else if (step_i) begin
      state_q <= lfsrNext(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/db_bounce_gen.sv
// db_bounce_gen: turns clean per-channel level commands into bouncing
// button lines. Each accepted command plays k glitches (level, then its
// inverse) and then holds the target level clean for SETTLE_CYC cycles.
// Optional macro DB_BOUNCE_GEN_SEED_PORT_EN adds seed_load/seed_val so the
// LFSR can be reseeded while idle.
module db_bounce_gen
  import db_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                MAX_BOUNCE = 3,
  parameter int                GLITCH_MAX = 3,
  parameter int                SETTLE_CYC = 8,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DB_BOUNCE_GEN_SEED_PORT_EN
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
`endif
  db_bounce_gen_if.slave    bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(((SETTLE_CYC > 16) ? SETTLE_CYC : 16) + 1);

  if (GLITCH_MAX < 1 || GLITCH_MAX > 15 || MAX_BOUNCE < 0 || MAX_BOUNCE > 15 ||
      SEED == '0 || SETTLE_CYC < DB_LIMIT + 1) begin : gBadParams
    $error("db_bounce_gen: illegal parameter set");
  end

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        left_q, left_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              lvl_q, lvl_d;
  logic [NUM_CH-1:0] btn_q, btn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [LFSR_W-1:0] lfsr;
  logic              lfsrLoad;
  logic [LFSR_W-1:0] lfsrLoadVal;
  logic [3:0]        unused_lfsr_hi;
  logic              accept;
  logic              chBad;
  logic [3:0]        kVal;
  logic [CNT_W-1:0]  glen;

`ifdef DB_BOUNCE_GEN_SEED_PORT_EN
  assign lfsrLoad    = seed_load && (state_q == IDLE);
  assign lfsrLoadVal = (seed_val == '0) ? SEED : seed_val;
`else
  assign lfsrLoad    = 1'b0;
  assign lfsrLoadVal = SEED;
`endif

  db_lfsr16 #(.SEED(SEED)) uLfsr (
    .clk        (clk),
    .rst        (rst),
    .step_i     (1'b1),
    .load_i     (lfsrLoad),
    .load_val_i (lfsrLoadVal),
    .state_o    (lfsr)
  );

  assign unused_lfsr_hi = lfsr[15:12];
  assign accept = bus.cmd_valid && (state_q == IDLE);
  assign chBad  = (32'(bus.cmd_ch) >= NUM_CH);
  assign kVal   = 4'(lfsr[7:0] % 8'(MAX_BOUNCE + 1));
  assign glen   = CNT_W'(lfsr[11:8] % 4'(GLITCH_MAX)) + CNT_W'(1);

  // State and registered outputs; reset drops every line immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= PH_A;
      cnt_q   <= '0;
      left_q  <= '0;
      ch_q    <= '0;
      lvl_q   <= 1'b0;
      btn_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      ch_q    <= ch_d;
      lvl_q   <= lvl_d;
      btn_q   <= btn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Sequencing: cnt_q counts down the cycles left in the current phase
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    ch_d    = ch_q;
    lvl_d   = lvl_q;
    case (state_q)
      IDLE: begin
        if (accept && !chBad) begin
          ch_d  = bus.cmd_ch;
          lvl_d = bus.cmd_level;
          if (kVal != 4'd0) begin
            state_d = BOUNCE;
            phase_d = PH_A;
            left_d  = kVal;
            cnt_d   = glen;
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYC);
          end
        end
      end
      BOUNCE: begin
        if (cnt_q == CNT_W'(1)) begin
          if (phase_q == PH_A) begin
            phase_d = PH_B;
            cnt_d   = glen;
          end else if (left_q == 4'd1) begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYC);
          end else begin
            left_d  = left_q - 4'd1;
            phase_d = PH_A;
            cnt_d   = glen;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line levels and pulses for the next cycle, decided at phase boundaries
  always_comb begin
    btn_d  = btn_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (chBad) begin
            err_d = 1'b1;
          end else begin
            btn_d[bus.cmd_ch] = bus.cmd_level;
          end
        end
      end
      BOUNCE: begin
        if (cnt_q == CNT_W'(1)) begin
          btn_d[ch_q] = (phase_q == PH_A) ? ~lvl_q : lvl_q;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.btn       = btn_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_db_bounce_gen.sv
// tb_db_bounce_gen: randomized bench for db_bounce_gen against a behavioural
// waveform model. Honours DB_BOUNCE_GEN_SEED_PORT_EN for the seed-port test.
module tb_db_bounce_gen;
  import db_pkg::*;

  localparam int          NUM_CH     = 4;
  localparam int          MAX_BOUNCE = 3;
  localparam int          GLITCH_MAX = 3;
  localparam int          SETTLE_CYC = 8;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  db_bounce_gen_if #(.NUM_CH(NUM_CH)) bus ();
  db_bounce_gen_if #(.NUM_CH(3))      bus3 ();

`ifdef DB_BOUNCE_GEN_SEED_PORT_EN
  logic        seedLoad = 1'b0;
  logic [15:0] seedVal  = 16'd0;
`endif

  db_bounce_gen #(
    .NUM_CH(NUM_CH), .MAX_BOUNCE(MAX_BOUNCE), .GLITCH_MAX(GLITCH_MAX),
    .SETTLE_CYC(SETTLE_CYC), .SEED(SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DB_BOUNCE_GEN_SEED_PORT_EN
    .seed_load (seedLoad),
    .seed_val  (seedVal),
`endif
    .bus       (bus)
  );

  db_bounce_gen #(
    .NUM_CH(3), .MAX_BOUNCE(MAX_BOUNCE), .GLITCH_MAX(GLITCH_MAX),
    .SETTLE_CYC(SETTLE_CYC), .SEED(SEED)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
`ifdef DB_BOUNCE_GEN_SEED_PORT_EN
    .seed_load (1'b0),
    .seed_val  (16'd0),
`endif
    .bus       (bus3)
  );

  int nChecks = 0;
  int nPass   = 0;

  logic [NUM_CH-1:0] mBtn;
  logic [NUM_CH-1:0] preBtn;
  logic [NUM_CH-1:0] obsBtn[$];
  logic              obsBusy[$];
  logic              obsDone[$];
  logic              obsRdy[$];
  logic [NUM_CH-1:0] expBtn[$];
  int                expBounce;
  logic [15:0]       mLfsr;

  // Reference shift: shift left, parity of the tapped bits enters at bit 0
  function automatic logic [15:0] refStep(input logic [15:0] x);
    return (x << 1) | {15'd0, ^(x & 16'hB400)};
  endfunction

  function automatic int kOf(input logic [15:0] l);
    return int'(l[7:0]) % (MAX_BOUNCE + 1);
  endfunction

  function automatic int glitchLen(input logic [15:0] l);
    return 1 + (int'(l[11:8]) % GLITCH_MAX);
  endfunction

  // Model copy of the generator's random source, advancing every cycle
  always @(posedge clk or posedge rst) begin
    if (rst) mLfsr <= SEED;
`ifdef DB_BOUNCE_GEN_SEED_PORT_EN
    else if (seedLoad) mLfsr <= (seedVal == 16'd0) ? SEED : seedVal;
`endif
    else mLfsr <= refStep(mLfsr);
  end

  // Expected line vector per cycle after the accept edge, ending with the done cycle
  task automatic buildExpected(input logic [15:0] l0, input int ch, input logic lvl);
    logic [15:0]       l;
    logic [NUM_CH-1:0] v;
    int                k, len;
    l = l0;
    v = mBtn;
    expBtn.delete();
    expBounce = 0;
    k = kOf(l0);
    for (int g = 0; g < k; g++) begin
      for (int ph = 0; ph < 2; ph++) begin
        len = glitchLen(l);
        v[ch] = (ph == 0) ? lvl : ~lvl;
        repeat (len) begin
          expBtn.push_back(v);
          l = refStep(l);
        end
        expBounce += len;
      end
    end
    v[ch] = lvl;
    repeat (SETTLE_CYC + 1) expBtn.push_back(v);
    mBtn = v;
  endtask

  // Issue one command (caller sits on a negedge, DUT idle) and record until busy drops
  task automatic captureCmd(input int ch, input logic lvl, input bit holdBusy);
    bit ended;
    preBtn = mBtn;
    buildExpected(mLfsr, ch, lvl);
    obsBtn.delete(); obsBusy.delete(); obsDone.delete(); obsRdy.delete();
    bus.cmd_ch    = 2'(ch);
    bus.cmd_level = lvl;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (holdBusy) begin
      bus.cmd_ch    = 2'((ch + 1) % NUM_CH);
      bus.cmd_level = ~lvl;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    ended = 1'b0;
    for (int i = 0; i < 200; i++) begin
      obsBtn.push_back(bus.btn);
      obsBusy.push_back(bus.busy);
      obsDone.push_back(bus.done);
      obsRdy.push_back(bus.cmd_ready);
      if (!bus.busy) begin
        ended = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    if (!ended) $display("[TB] FAIL capture_timeout: busy still %b after 200 cycles, required 0", bus.busy);
  endtask

  task automatic test_reset();
    int w, nDone;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nChecks++; if (bus.btn !== 4'b0000) $display("[TB] FAIL reset_btn: got %b want 0000", bus.btn); else nPass++;
    nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else nPass++;
    nChecks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) $display("[TB] FAIL reset_pulses: done %b err %b want 0 0", bus.done, bus.err); else nPass++;
    rst = 1'b0;
    mBtn = '0;
    @(negedge clk);
    nChecks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", bus.cmd_ready); else nPass++;
    w = 0;
    while (kOf(mLfsr) == 0 && w < 64) begin @(negedge clk); w++; end
    nChecks++; if (kOf(mLfsr) == 0) $display("[TB] FAIL reset_wait_k: k %0d want nonzero", kOf(mLfsr)); else nPass++;
    bus.cmd_ch = 2'(CH_VS); bus.cmd_level = 1'b1; bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    nChecks++; if (bus.busy !== 1'b1 || bus.btn !== 4'b0010) $display("[TB] FAIL reset_pre_bounce: busy %b btn %b want 1 0010", bus.busy, bus.btn); else nPass++;
    #2 rst = 1'b1;
    #1;
    nChecks++; if (bus.btn !== 4'b0000 || bus.busy !== 1'b0) $display("[TB] FAIL reset_abort: btn %b busy %b want 0000 0", bus.btn, bus.busy); else nPass++;
    @(negedge clk);
    rst = 1'b0;
    mBtn = '0;
    nDone = 0;
    @(negedge clk);
    nChecks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready_after_abort: got %b want 1", bus.cmd_ready); else nPass++;
    repeat (12) begin
      if (bus.done === 1'b1 || bus.busy !== 1'b0) nDone++;
      @(negedge clk);
    end
    nChecks++; if (nDone != 0) $display("[TB] FAIL reset_no_done: %0d cycles with done/busy, want 0", nDone); else nPass++;
  endtask

  task automatic test_clean_edge();
    int w;
    w = 0;
    while (kOf(mLfsr) != 0 && w < 64) begin @(negedge clk); w++; end
    nChecks++; if (kOf(mLfsr) != 0) $display("[TB] FAIL clean_wait_k: k %0d want 0", kOf(mLfsr)); else nPass++;
    captureCmd(CH_HS, 1'b1, 1'b0);
    nChecks++;
    if (obsBtn.size() != SETTLE_CYC + 1) $display("[TB] FAIL clean_length: %0d cycles want %0d", obsBtn.size(), SETTLE_CYC + 1);
    else begin
      nPass++;
      for (int i = 0; i < SETTLE_CYC; i++) begin
        nChecks++;
        if (obsBtn[i] !== 4'b0001 || obsBusy[i] !== 1'b1 || obsDone[i] !== 1'b0)
          $display("[TB] FAIL clean_cycle%0d: btn %b busy %b done %b want 0001 1 0", i, obsBtn[i], obsBusy[i], obsDone[i]);
        else nPass++;
      end
      nChecks++;
      if (obsDone[SETTLE_CYC] !== 1'b1 || obsRdy[SETTLE_CYC] !== 1'b1 || obsBtn[SETTLE_CYC] !== 4'b0001)
        $display("[TB] FAIL clean_done: done %b ready %b btn %b want 1 1 0001", obsDone[SETTLE_CYC], obsRdy[SETTLE_CYC], obsBtn[SETTLE_CYC]);
      else nPass++;
    end
    @(negedge clk);
    nChecks++; if (bus.done !== 1'b0) $display("[TB] FAIL clean_done_width: done %b want 0", bus.done); else nPass++;
  endtask

  task automatic test_bounce_bound();
    int ch, run, maxRun, dbCnt, last;
    logic lvl, db, prev, changed;
    for (int n = 0; n < 500; n++) begin
      ch  = $urandom_range(0, NUM_CH - 1);
      lvl = 1'($urandom_range(0, 1));
      captureCmd(ch, lvl, 1'b0);
      last = expBtn.size() - 1;
      nChecks++;
      if (obsBtn.size() != expBtn.size()) $display("[TB] FAIL bound_length cmd%0d: %0d cycles want %0d", n, obsBtn.size(), expBtn.size());
      else begin
        nPass++;
        for (int i = 0; i <= last; i++) begin
          nChecks++;
          if (obsBtn[i] !== expBtn[i] || obsBusy[i] !== (i != last) || obsDone[i] !== (i == last))
            $display("[TB] FAIL bound_wave cmd%0d cyc%0d: btn %b busy %b done %b want %b %b %b",
                     n, i, obsBtn[i], obsBusy[i], obsDone[i], expBtn[i], (i != last), (i == last));
          else nPass++;
        end
      end
      run = 0; maxRun = 0; prev = 1'bx;
      for (int i = 0; i < expBounce && i < obsBtn.size(); i++) begin
        if (i > 0 && obsBtn[i][ch] === prev) run++; else run = 1;
        prev = obsBtn[i][ch];
        if (run > maxRun) maxRun = run;
      end
      nChecks++;
      if (maxRun > GLITCH_MAX || (expBounce > 0 && maxRun < 1))
        $display("[TB] FAIL bound_run cmd%0d: longest run %0d want 1..%0d", n, maxRun, GLITCH_MAX);
      else nPass++;
      db = preBtn[ch]; dbCnt = 0; changed = 1'b0;
      for (int i = 0; i < obsBtn.size(); i++) begin
        if (obsBtn[i][ch] !== db) dbCnt++; else dbCnt = 0;
        if (dbCnt >= DB_LIMIT) begin
          db = obsBtn[i][ch]; dbCnt = 0;
          if (i < expBounce) changed = 1'b1;
        end
      end
      nChecks++; if (changed) $display("[TB] FAIL bound_debounce cmd%0d: debounced level changed during bounce, want stable", n); else nPass++;
      nChecks++;
      if (obsBtn.size() == 0 || obsBtn[obsBtn.size()-1][ch] !== lvl)
        $display("[TB] FAIL bound_final cmd%0d: final level %b want %b", n, (obsBtn.size() == 0) ? 1'bx : obsBtn[obsBtn.size()-1][ch], lvl);
      else nPass++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_noise_burst();
    int w, run, maxZero, dbCnt, last;
    logic db;
    captureCmd(CH_DF_UART, 1'b1, 1'b0);
    nChecks++; if (bus.btn[CH_DF_UART] !== 1'b1) $display("[TB] FAIL noise_prep: btn[2] %b want 1", bus.btn[CH_DF_UART]); else nPass++;
    for (int n = 0; n < 20; n++) begin
      w = 0;
      while (kOf(mLfsr) == 0 && w < 64) begin @(negedge clk); w++; end
      captureCmd(CH_DF_UART, 1'b1, 1'b0);
      last = expBtn.size() - 1;
      nChecks++;
      if (obsBtn.size() != expBtn.size()) $display("[TB] FAIL noise_length burst%0d: %0d cycles want %0d", n, obsBtn.size(), expBtn.size());
      else begin
        nPass++;
        for (int i = 0; i <= last; i++) begin
          nChecks++;
          if (obsBtn[i] !== expBtn[i]) $display("[TB] FAIL noise_wave burst%0d cyc%0d: btn %b want %b", n, i, obsBtn[i], expBtn[i]);
          else nPass++;
        end
      end
      run = 0; maxZero = 0; db = 1'b1; dbCnt = 0;
      for (int i = 0; i < obsBtn.size(); i++) begin
        if (obsBtn[i][CH_DF_UART] === 1'b0) run++; else run = 0;
        if (run > maxZero) maxZero = run;
        if (obsBtn[i][CH_DF_UART] !== db) dbCnt++; else dbCnt = 0;
        if (dbCnt >= DB_LIMIT) begin db = obsBtn[i][CH_DF_UART]; dbCnt = 0; end
      end
      nChecks++; if (maxZero > GLITCH_MAX) $display("[TB] FAIL noise_dip burst%0d: zero run %0d want <= %0d", n, maxZero, GLITCH_MAX); else nPass++;
      nChecks++; if (db !== 1'b1) $display("[TB] FAIL noise_debounce burst%0d: debounced %b want 1", n, db); else nPass++;
      nChecks++; if (bus.btn[CH_DF_UART] !== 1'b1) $display("[TB] FAIL noise_final burst%0d: btn[2] %b want 1", n, bus.btn[CH_DF_UART]); else nPass++;
    end
  endtask

  task automatic test_busy_ignored();
    logic lvl;
    int last;
    lvl = ~mBtn[CH_VS];
    captureCmd(CH_VS, lvl, 1'b1);
    last = expBtn.size() - 1;
    nChecks++;
    if (obsBtn.size() != expBtn.size()) $display("[TB] FAIL busy_length: %0d cycles want %0d", obsBtn.size(), expBtn.size());
    else begin
      nPass++;
      for (int i = 0; i <= last; i++) begin
        nChecks++;
        if (obsBtn[i] !== expBtn[i] || obsRdy[i] !== (i == last))
          $display("[TB] FAIL busy_wave cyc%0d: btn %b ready %b want %b %b", i, obsBtn[i], obsRdy[i], expBtn[i], (i == last));
        else nPass++;
      end
    end
    @(negedge clk);
    nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL busy_not_queued: busy %b want 0", bus.busy); else nPass++;
  endtask

  task automatic test_invalid_ch();
    int w;
    nChecks++; if (bus3.err !== 1'b0) $display("[TB] FAIL invalid_pre_err: err %b want 0", bus3.err); else nPass++;
    bus3.cmd_ch = 2'd3; bus3.cmd_level = 1'b1; bus3.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    nChecks++;
    if (bus3.err !== 1'b1 || bus3.busy !== 1'b0 || bus3.btn !== 3'b000 || bus3.cmd_ready !== 1'b1)
      $display("[TB] FAIL invalid_err: err %b busy %b btn %b ready %b want 1 0 000 1", bus3.err, bus3.busy, bus3.btn, bus3.cmd_ready);
    else nPass++;
    @(negedge clk);
    nChecks++; if (bus3.err !== 1'b0 || bus3.busy !== 1'b0) $display("[TB] FAIL invalid_err_width: err %b busy %b want 0 0", bus3.err, bus3.busy); else nPass++;
    bus3.cmd_ch = 2'd2; bus3.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    nChecks++;
    if (bus3.err !== 1'b0 || bus3.busy !== 1'b1 || bus3.btn !== 3'b100)
      $display("[TB] FAIL valid_ch_on3: err %b busy %b btn %b want 0 1 100", bus3.err, bus3.busy, bus3.btn);
    else nPass++;
    w = 0;
    while (bus3.busy === 1'b1 && w < 80) begin @(negedge clk); w++; end
    nChecks++; if (bus3.busy !== 1'b0 || bus3.btn !== 3'b100) $display("[TB] FAIL valid_ch_on3_end: busy %b btn %b want 0 100", bus3.busy, bus3.btn); else nPass++;
  endtask

`ifdef DB_BOUNCE_GEN_SEED_PORT_EN
  task automatic test_seed_port();
    logic [NUM_CH-1:0] first[$];
    captureCmd(CH_DF_VGA, 1'b1, 1'b0);
    for (int rep = 0; rep < 3; rep++) begin
      seedVal  = (rep < 2) ? 16'h1234 : 16'h0000;
      seedLoad = 1'b1;
      @(negedge clk);
      seedLoad = 1'b0;
      captureCmd(CH_DF_VGA, 1'b1, 1'b0);
      nChecks++;
      if (obsBtn.size() != expBtn.size()) $display("[TB] FAIL seed_length rep%0d: %0d cycles want %0d", rep, obsBtn.size(), expBtn.size());
      else begin
        nPass++;
        for (int i = 0; i < expBtn.size(); i++) begin
          nChecks++;
          if (obsBtn[i] !== expBtn[i]) $display("[TB] FAIL seed_wave rep%0d cyc%0d: btn %b want %b", rep, i, obsBtn[i], expBtn[i]);
          else nPass++;
        end
      end
      if (rep == 0) first = obsBtn;
      if (rep == 1) begin
        nChecks++;
        if (first != obsBtn) $display("[TB] FAIL seed_repeat: sizes %0d/%0d, waveforms differ, want identical", first.size(), obsBtn.size());
        else nPass++;
      end
    end
  endtask
`endif

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cmd_valid  = 1'b0; bus.cmd_ch  = '0; bus.cmd_level  = 1'b0;
    bus3.cmd_valid = 1'b0; bus3.cmd_ch = '0; bus3.cmd_level = 1'b0;
    mBtn = '0;
    test_reset();
    test_clean_edge();
    test_bounce_bound();
    test_noise_burst();
    test_busy_ignored();
    test_invalid_ch();
`ifdef DB_BOUNCE_GEN_SEED_PORT_EN
    test_seed_port();
`endif
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/db_bounce_gen.md
Name: db_bounce_gen

Overview:
- Synthesizable mechanical-contact bounce emulator; the driving end of the debouncer input path.
- Turns clean per-channel level commands into noisy, bouncing button lines btn[NUM_CH-1:0].
- Channel order is HS, VS, DF_UART, DF_VGA.
- Sits in the DB bench and in the FPGA self-test build, upstream of the debouncer inputs.

Parameters:
- NUM_CH, 4, number of button lines driven.
- MAX_BOUNCE, 3, maximum glitch pulses per command (0..15).
- GLITCH_MAX, 3, maximum length in cycles of one glitch half-phase (1..15); kept below debouncer LIMIT.
- SETTLE_CYC, 8, cycles the target level is held clean before done; at least LIMIT+1.
- SEED, 16'hACE1, LFSR reset seed (non-zero).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_ch  in  $clog2(NUM_CH)  target channel.
- cmd_level  in  1  final clean level for that channel.
- btn  out  NUM_CH  emulated raw button lines, registered.
- busy  out  1  high in BOUNCE or SETTLE.
- done  out  1  one-cycle pulse at end of SETTLE.
- err  out  1  one-cycle pulse on an accepted command with cmd_ch >= NUM_CH.

Behaviour:
Reset (async, active-high):
- btn = 0, cmd_ready = 1 after release, busy = 0, done = 0, err = 0.
- State IDLE; LFSR = SEED.
- Reset mid-operation aborts immediately: no done, lines return to 0.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11; advances every cycle, including in IDLE.

Handshake:
- Accept when cmd_valid && cmd_ready; one command in flight at a time.
- On an accepted command with an invalid cmd_ch: err pulses the next cycle, btn is unchanged, state stays IDLE.

On a valid accept:
- Latch ch, lvl.
- k = lfsr[7:0] mod (MAX_BOUNCE+1).
- Go to BOUNCE if k > 0, otherwise to SETTLE.

BOUNCE:
- Runs k glitches; each glitch is phase A then phase B.
- Phase A drives btn[ch] = lvl for LA cycles; phase B drives btn[ch] = ~lvl for LB cycles.
- Each length = 1 + (lfsr[11:8] mod GLITCH_MAX), sampled at phase start.
- After the k-th phase B, go to SETTLE.

SETTLE:
- btn[ch] = lvl for exactly SETTLE_CYC cycles.
- Then done = 1 for one cycle; return to IDLE, so cmd_ready = 1 in the same cycle as done.

Latency:
- The first change on btn[ch] appears on the cycle after the accept edge.
- Total busy cycles = sum of all LA and LB + SETTLE_CYC.

Boundary cases:
- cmd_level equal to the current btn[ch]: pure noise burst; the line ends unchanged.
- k = 0: clean edge straight into SETTLE.
- Untargeted channels hold their value throughout.
- cmd_valid while busy: ignored, not queued; the initiator must hold it.
- A glitch phase never exceeds GLITCH_MAX cycles.
- Assertion: parameter legality checked at elaboration (GLITCH_MAX >= 1, MAX_BOUNCE <= 15, SEED != 0).

Optional Feature:
Macro: DB_BOUNCE_GEN_SEED_PORT_EN
- Defined: adds ports seed_load (in, 1) and seed_val (in, 16).
  - In IDLE, seed_load = 1 loads seed_val into the LFSR on the next edge; a zero seed_val loads SEED instead.
  - seed_load is ignored while busy.
- Undefined: no extra ports; the LFSR is seeded only from SEED at reset.

Decomposition:
- Shared package db_pkg holds:
  - state enum {IDLE, BOUNCE, SETTLE};
  - phase enum {PH_A, PH_B};
  - channel constants CH_HS = 0, CH_VS = 1, CH_DF_UART = 2, CH_DF_VGA = 3;
  - LFSR_W = 16 and DB_LIMIT = 4, shared with the debouncer checks.
- One sub-module, db_lfsr16: step enable, load, load value, 16-bit state out.

Test Plan:
- Reset: rst high mid-BOUNCE on CH_VS -> btn = 4'b0000 and busy = 0 immediately; cmd_ready = 1 on the first edge after release; no done.
- Clean edge: force k = 0 via seed, cmd ch = CH_HS, lvl = 1 -> btn[0] rises one cycle after accept, stays 1 for 8 cycles, done pulses, cmd_ready = 1 in the done cycle.
- Bounce bound: 500 random commands, MAX_BOUNCE = 3, GLITCH_MAX = 3 -> no btn run shorter than 1 or longer than 3 cycles inside BOUNCE; debouncer output changes only in SETTLE; final btn[ch] = lvl.
- Noise burst: btn[2] = 1, cmd ch = CH_DF_UART, lvl = 1 -> btn[2] dips to 0 for runs of at most 3 cycles; DF_UART never drops (DB_LIMIT = 4); ends at 1.
- Invalid channel: NUM_CH = 3, cmd_ch = 3 -> err pulse one cycle after accept, btn unchanged, no busy.
- Seed port (macro defined): load seed_val = 16'h1234 twice, issue the same command each time -> identical btn waveforms; seed_val = 0 -> behaves as SEED.
